// File: rtl/serial_pe_feeder_pkg.sv
// Shared definitions for the serial PE feeder and its address generator.
// Holds PE bus widths, pe_ctl flag encodings and the sequencer state encoding.
// No logic lives here; everything is a constant or a type.
package serial_pe_feeder_pkg;

  localparam int PE_DW = 16;  // neuron / weight width
  localparam int PE_RW = 32;  // PE result width

  localparam logic [1:0] PE_CTL_FIRST = 2'b01;
  localparam logic [1:0] PE_CTL_LAST  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_WRITE    = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

endpackage

// File: rtl/serial_pe_addr_gen.sv
// Element/output counters and running weight pointer for the serial PE feeder.
// Latency: addresses and flags are combinational views of registered counters.
// Backpressure: none; counters advance only when the sequencer steps them.
module serial_pe_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [LEN_W-1:0]  i_vec_len,
  input  logic [LEN_W-1:0]  i_out_num,
  input  logic              i_step,
  input  logic              i_next,
  output logic [ADDR_W-1:0] o_n_raddr,
  output logic [ADDR_W-1:0] o_w_raddr,
  output logic [ADDR_W-1:0] o_j,
  output logic              o_first,
  output logic              o_last,
  output logic              o_last_out
);

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_num;
  logic [LEN_W-1:0]  r_k;
  logic [LEN_W-1:0]  r_j;
  logic [ADDR_W-1:0] r_wptr;
  logic              w_last;

  assign w_last     = (r_k == r_len - LEN_W'(1));
  assign o_first    = (r_k == '0);
  assign o_last     = w_last;
  assign o_last_out = (r_j == r_num - LEN_W'(1));
  assign o_n_raddr  = ADDR_W'(r_k);
  assign o_w_raddr  = r_wptr;
  assign o_j        = ADDR_W'(r_j);

  // Latch layer shape on start; walk k per element and j per output.
  // The weight pointer never rewinds, so it tracks j*K+k without a multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_num  <= '0;
      r_k    <= '0;
      r_j    <= '0;
      r_wptr <= '0;
    end else if (i_load) begin
      r_len  <= i_vec_len;
      r_num  <= i_out_num;
      r_k    <= '0;
      r_j    <= '0;
      r_wptr <= '0;
    end else begin
      if (i_step) begin
        r_wptr <= r_wptr + ADDR_W'(1);
        r_k    <= w_last ? '0 : r_k + LEN_W'(1);
      end
      if (i_next) begin
        r_j <= r_j + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_pe_feeder.sv
// Streams K neuron/weight pairs per output into a serial PE and writes N results.
// Latency: K+3 cycles per output with a PE that answers one cycle after last input.
// Backpressure: none on the PE side; WAIT_RES holds indefinitely for pe_vld_o.
module serial_pe_feeder
  import serial_pe_feeder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [LEN_W-1:0]  out_num,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] n_raddr,
  output logic              n_ren,
  input  logic [PE_DW-1:0]  n_rdata,
  output logic [ADDR_W-1:0] w_raddr,
  output logic              w_ren,
  input  logic [PE_DW-1:0]  w_rdata,
  output logic [PE_DW-1:0]  pe_neuron,
  output logic [PE_DW-1:0]  pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld_i,
  input  logic [PE_RW-1:0]  pe_result,
  input  logic              pe_vld_o,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [PE_RW-1:0]  o_wdata,
  output logic              o_we
);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_ren;
  logic              r_pe_vld;
  logic [1:0]        r_pe_ctl;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [PE_RW-1:0]  r_wdata;

  logic              w_load;
  logic              w_step;
  logic              w_next;
  logic              w_zero;
  logic              w_first;
  logic              w_last;
  logic              w_last_out;
  logic [ADDR_W-1:0] w_n_addr;
  logic [ADDR_W-1:0] w_w_addr;
  logic [ADDR_W-1:0] w_j;
  logic [1:0]        w_ctl;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_step = (r_state == ST_RUN);
  assign w_next = (r_state == ST_WRITE) && !w_last_out;
  assign w_zero = (vec_len == '0) || (out_num == '0);
  assign w_ctl  = (w_first ? PE_CTL_FIRST : 2'b00) | (w_last ? PE_CTL_LAST : 2'b00);

  serial_pe_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_vec_len  (vec_len),
    .i_out_num  (out_num),
    .i_step     (w_step),
    .i_next     (w_next),
    .o_n_raddr  (w_n_addr),
    .o_w_raddr  (w_w_addr),
    .o_j        (w_j),
    .o_first    (w_first),
    .o_last     (w_last),
    .o_last_out (w_last_out)
  );

  // Layer sequencer; every control output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ren    <= 1'b0;
      r_pe_vld <= 1'b0;
      r_pe_ctl <= 2'b00;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      // Data stage trails the read by one cycle to line up with buffer latency.
      r_pe_vld <= (r_state == ST_RUN);
      r_pe_ctl <= (r_state == ST_RUN) ? w_ctl : 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_zero) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_ren   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_WAIT_RES;
            r_ren   <= 1'b0;
          end
        end
        ST_WAIT_RES: begin
          // Results arriving in any other state are stray and dropped.
          if (pe_vld_o) begin
            r_state <= ST_WRITE;
            r_wdata <= pe_result;
            r_waddr <= w_j;
            r_we    <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (w_last_out) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_ren   <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ren   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign n_ren     = r_ren;
  assign w_ren     = r_ren;
  assign n_raddr   = r_ren ? w_n_addr : '0;
  assign w_raddr   = r_ren ? w_w_addr : '0;
  // Buffer data is forwarded only while valid so idle cycles present zeros.
  assign pe_neuron = r_pe_vld ? n_rdata : '0;
  assign pe_weight = r_pe_vld ? w_rdata : '0;
  assign pe_vld_i  = r_pe_vld;
  assign pe_ctl    = r_pe_ctl;
  assign o_we      = r_we;
  assign o_waddr   = r_waddr;
  assign o_wdata   = r_wdata;

endmodule

// File: tb/tb_serial_pe_feeder.sv
module tb_serial_pe_feeder;

  localparam int AW = 10;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [LW-1:0] vec_len, out_num;
  logic          busy, done, n_ren, w_ren, pe_vld_i, o_we, pe_vld_o;
  logic [AW-1:0] n_raddr, w_raddr, o_waddr;
  logic [15:0]   n_rdata, w_rdata, pe_neuron, pe_weight;
  logic [1:0]    pe_ctl;
  logic [31:0]   pe_result, o_wdata;

  always #5 clk = ~clk;

  serial_pe_feeder #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .out_num(out_num),
    .busy(busy), .done(done),
    .n_raddr(n_raddr), .n_ren(n_ren), .n_rdata(n_rdata),
    .w_raddr(w_raddr), .w_ren(w_ren), .w_rdata(w_rdata),
    .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld_i(pe_vld_i),
    .pe_result(pe_result), .pe_vld_o(pe_vld_o),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_we(o_we)
  );

  // Synchronous read buffers
  logic [15:0] nmem [0:63];
  logic [15:0] wmem [0:63];
  always @(posedge clk) begin
    if (n_ren) n_rdata <= nmem[n_raddr[5:0]];
    if (w_ren) w_rdata <= wmem[w_raddr[5:0]];
  end

  // Serial PE model: result one cycle after last element, plus pe_delay extra cycles
  logic [2:0]         pe_delay;
  logic               spur;
  logic [7:0]         vsh;
  logic signed [31:0] acc, res_hold, pe_prod, pe_sum;
  assign pe_prod   = 32'($signed(pe_neuron)) * 32'($signed(pe_weight));
  assign pe_sum    = pe_ctl[0] ? pe_prod : acc + pe_prod;
  assign pe_vld_o  = vsh[pe_delay] | spur;
  assign pe_result = spur ? 32'hDEAD_BEEF : res_hold;
  always @(posedge clk) begin
    if (!rst_n) begin
      vsh      <= '0;
      acc      <= '0;
      res_hold <= '0;
    end else begin
      vsh <= {vsh[6:0], pe_vld_i & pe_ctl[1]};
      if (pe_vld_i) begin
        acc <= pe_sum;
        if (pe_ctl[1]) res_hold <= pe_sum;
      end
    end
  end

  // Scoreboard queues
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [AW-1:0] na; logic [AW-1:0] wa; } rd_t;
  typedef struct packed { logic [1:0] c; logic [15:0] n; logic [15:0] w; } dat_t;
  typedef struct packed { int rel; int nwr; int nrd; int nbusy; } lay_t;
  wr_t  q_wr[$];
  rd_t  q_rd[$];
  dat_t q_dat[$];
  lay_t q_lay[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge and pops expectations as outputs appear
  logic rst_at_edge;
  always @(posedge clk) rst_at_edge <= rst_n;

  int   layers_seen = 0;
  bit   act = 1'b0;
  int   rel, c_wr, c_rd, c_busy;
  wr_t  e_wr;
  rd_t  e_rd;
  dat_t e_dat;
  lay_t e_lay;

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      chk("reset_ctl_addr", {busy, done, n_ren, w_ren, pe_vld_i, o_we, pe_ctl, n_raddr, w_raddr, o_waddr}, 64'd0);
      chk("reset_data", {pe_neuron, pe_weight, o_wdata}, 64'd0);
      act = 1'b0;
    end else begin
      if (act) begin
        rel++;
        if (n_ren) c_rd++;
        if (o_we)  c_wr++;
        if (busy)  c_busy++;
      end
      if (n_ren || w_ren) begin
        if (q_rd.size() == 0) chk("rd_extra", n_ren, 0);
        else begin
          e_rd = q_rd.pop_front();
          chk("rd_addr", {n_ren, w_ren, n_raddr, w_raddr}, {2'b11, e_rd.na, e_rd.wa});
        end
      end
      if (pe_vld_i) begin
        if (q_dat.size() == 0) chk("pe_vld_extra", pe_vld_i, 0);
        else begin
          e_dat = q_dat.pop_front();
          chk("pe_ctl_data", {pe_ctl, pe_neuron, pe_weight}, {e_dat.c, e_dat.n, e_dat.w});
        end
      end else begin
        chk("pe_ctl_idle", pe_ctl, 0);
      end
      if (o_we) begin
        if (q_wr.size() == 0) chk("wr_extra", o_we, 0);
        else begin
          e_wr = q_wr.pop_front();
          chk("write", {o_waddr, o_wdata}, {e_wr.a, e_wr.d});
        end
      end
      if (done) begin
        if (!act || q_lay.size() == 0) chk("done_extra", done, 0);
        else begin
          e_lay = q_lay.pop_front();
          chk("done_cycle", rel, e_lay.rel);
          chk("write_count", c_wr, e_lay.nwr);
          chk("read_count", c_rd, e_lay.nrd);
          chk("busy_cycles", c_busy, e_lay.nbusy);
          layers_seen++;
        end
        act = 1'b0;
      end
      if (act && rel > 3000) begin
        chk("layer_timeout", done, 1);
        act = 1'b0;
        layers_seen++;
      end
      if (start && !busy && !act) begin
        act    = 1'b1;
        rel    = 0;
        c_wr   = 0;
        c_rd   = 0;
        c_busy = 0;
      end
    end
  end

  // Stimulus helpers
  task automatic push_run(input int k_len, input int n_out);
    for (int j = 0; j < n_out; j++)
      for (int k = 0; k < k_len; k++) begin
        q_rd.push_back('{na: AW'(k), wa: AW'(j*k_len + k)});
        q_dat.push_back('{c: {(k == k_len-1), (k == 0)}, n: nmem[k], w: wmem[j*k_len + k]});
      end
  endtask

  task automatic push_lay(input int r, input int nwr, input int nrd, input int nbusy);
    q_lay.push_back('{rel: r, nwr: nwr, nrd: nrd, nbusy: nbusy});
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    q_wr.push_back('{a: AW'(a), d: d});
  endtask

  task automatic issue(input int k_len, input int n_out);
    @(posedge clk); #1;
    vec_len = LW'(k_len);
    out_num = LW'(n_out);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    vec_len = LW'(7);
    out_num = LW'(9);
  endtask

  task automatic wait_layers(input int target);
    for (int i = 0; i < 4000 && layers_seen < target; i++) @(posedge clk);
    if (layers_seen < target) begin
      $display("FAIL layer_wait: layers %0d expected %0d", layers_seen, target);
      $fatal(1, "layer did not complete");
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_len = '0; out_num = '0;
    pe_delay = 3'd0; spur = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // K=3 N=1: 1*4+2*5+3*6 = 32
    nmem[0] = 16'd1; nmem[1] = 16'd2; nmem[2] = 16'd3;
    wmem[0] = 16'd4; wmem[1] = 16'd5; wmem[2] = 16'd6;
    push_run(3, 1); push_wr(0, 32'd32); push_lay(7, 1, 3, 6);
    issue(3, 1); wait_layers(1);

    // K=1 N=2: -2*7 = -14, -2*3 = -6
    nmem[0] = 16'hFFFE; wmem[0] = 16'd7; wmem[1] = 16'd3;
    push_run(1, 2); push_wr(0, 32'hFFFF_FFF2); push_wr(1, 32'hFFFF_FFFA); push_lay(9, 2, 2, 8);
    issue(1, 2); wait_layers(2);

    // K=4 N=3: outputs 30, 70, 110; 21 cycles of busy
    for (int i = 0; i < 4; i++) nmem[i] = 16'(i + 1);
    for (int i = 0; i < 12; i++) wmem[i] = 16'(i + 1);
    push_run(4, 3); push_wr(0, 32'd30); push_wr(1, 32'd70); push_wr(2, 32'd110);
    push_lay(22, 3, 12, 21);
    issue(4, 3); wait_layers(3);

    // Degenerate shapes: straight to FIN, no traffic
    push_lay(1, 0, 0, 0); issue(0, 2); wait_layers(4);
    push_lay(1, 0, 0, 0); issue(3, 0); wait_layers(5);

    // Second start during RUN is ignored
    nmem[0] = 16'd1; nmem[1] = 16'd2; nmem[2] = 16'd3;
    wmem[0] = 16'd4; wmem[1] = 16'd5; wmem[2] = 16'd6;
    push_run(3, 1); push_wr(0, 32'd32); push_lay(7, 1, 3, 6);
    issue(3, 1);
    start = 1'b1; vec_len = LW'(5); out_num = LW'(4);
    @(posedge clk); #1 start = 1'b0;
    wait_layers(6);

    // Reset while waiting for a slow result: aborts with no write
    pe_delay = 3'd5;
    nmem[0] = 16'd3; nmem[1] = 16'hFFFF;
    wmem[0] = 16'd2; wmem[1] = 16'd4; wmem[2] = 16'hFFFB; wmem[3] = 16'd6;
    push_run(2, 1);
    issue(2, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q_rd.delete(); q_dat.delete(); q_wr.delete(); q_lay.delete();
    pe_delay = 3'd0;
    repeat (4) @(posedge clk);
    // Clean restart: 3*2 + -1*4 = 2
    push_run(2, 1); push_wr(0, 32'd2); push_lay(6, 1, 2, 5);
    issue(2, 1); wait_layers(7);

    // Slow PE (5 extra cycles) plus a stray pe_vld_o during RUN: outputs 2 and -21
    pe_delay = 3'd5;
    push_run(2, 2); push_wr(0, 32'd2); push_wr(1, 32'hFFFF_FFEB); push_lay(21, 2, 4, 20);
    issue(2, 2);
    spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    wait_layers(8);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
